div_seq_ctrl: RTL and testbench

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_seq_ctrl_if.sv | 27 ++
 rtl/div_seq_ctrl_lzc33.sv | 20 ++
 rtl/div_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider sequencing controller.
// Contents: operation encodings, FSM state type, data widths and the
// 33-bit magnitude helper used to prepare core operands.
package div_pkg;

    localparam int DATA_W = 32;
    localparam int OPU_W  = DATA_W + 1;
    localparam int LZC_W  = 6;

    // req_op encodings; bit 0 = unsigned, bit 1 = remainder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

    // Magnitude of a 32-bit operand widened to 33 bits. Negating the
    // sign-extended value keeps 0x80000000 representable as +2^31.
    function automatic logic [OPU_W-1:0] abs33(input logic [DATA_W-1:0] v,
                                               input logic              sgn);
        logic [OPU_W-1:0] ext;
        ext = {sgn & v[DATA_W-1], v};
        return (sgn & v[DATA_W-1]) ? (~ext + OPU_W'(1)) : ext;
    endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/response bus between a requester and div_seq_ctrl.
// Signals: req_valid/req_ready/req_op/req_a/req_b (request channel),
//          rsp_valid/rsp_ready/rsp_data (response channel).
// Modports: master = requester side, slave = controller side.
interface div_seq_ctrl_if;
    import div_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/div_seq_ctrl_lzc33.sv
// lzc33: leading-zero count of a 33-bit value.
// Ports: i_val (33-bit input), o_cnt (6-bit count, 33 when i_val is zero).
module lzc33
    import div_pkg::*;
(
    input  logic [OPU_W-1:0] i_val,
    output logic [LZC_W-1:0] o_cnt
);

    // Ascending scan: the highest set bit is the last one to write o_cnt.
    always_comb begin
        o_cnt = LZC_W'(OPU_W);
        for (int i = 0; i < OPU_W; i++) begin
            if (i_val[i]) begin
                o_cnt = LZC_W'(OPU_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequences one divide/remainder request through an external
// iterative divider core (IDLE -> PREP -> RUN -> DONE).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         request/response handshake (div_seq_ctrl_if)
//   flush / busy        abort current operation / controller not idle
//   dv_a, dv_b, dv_sign raw operands and signedness for the core
//   dv_en               core enable, high throughout RUN
//   dv_a_opuns/b_opuns  33-bit operand magnitudes
//   dv_n1, dv_n2        leading-zero counts of the magnitudes
//   dv_quo, dv_rem      core results; dv_busy core stall indication
// Build option: define DIV_RESULT_CACHE_EN to add a last-result cache that
// answers a repeated (a, b, signedness) request straight from IDLE to DONE.
module div_seq_ctrl
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    div_seq_ctrl_if.slave     bus,
    input  logic              flush,
    output logic              busy,
    output logic [DATA_W-1:0] dv_a,
    output logic [DATA_W-1:0] dv_b,
    output logic              dv_sign,
    output logic              dv_en,
    output logic [OPU_W-1:0]  dv_a_opuns,
    output logic [OPU_W-1:0]  dv_b_opuns,
    output logic [LZC_W-1:0]  dv_n1,
    output logic [LZC_W-1:0]  dv_n2,
    input  logic [DATA_W-1:0] dv_quo,
    input  logic [DATA_W-1:0] dv_rem,
    input  logic              dv_busy
);

    div_state_e        r_state;
    div_state_e        w_next;
    logic              r_rst_done;   // keeps req_ready low until first edge after reset
    logic              r_first_run;  // marks the core start cycle
    logic              r_op_rem;
    logic [DATA_W-1:0] r_dv_a;
    logic [DATA_W-1:0] r_dv_b;
    logic              r_dv_sign;
    logic [OPU_W-1:0]  r_a_opuns;
    logic [OPU_W-1:0]  r_b_opuns;
    logic [LZC_W-1:0]  r_n1;
    logic [LZC_W-1:0]  r_n2;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;

    logic              w_ready;
    logic              w_accept;
    logic              w_capture;
    logic [OPU_W-1:0]  w_a_abs;
    logic [OPU_W-1:0]  w_b_abs;
    logic [LZC_W-1:0]  w_n1;
    logic [LZC_W-1:0]  w_n2;

`ifdef DIV_RESULT_CACHE_EN
    logic [DATA_W-1:0] r_c_a;
    logic [DATA_W-1:0] r_c_b;
    logic              r_c_sign;
    logic [DATA_W-1:0] r_c_quo;
    logic [DATA_W-1:0] r_c_rem;
    logic              r_c_vld;
    logic              w_hit;

    assign w_hit = r_c_vld && (bus.req_a == r_c_a) && (bus.req_b == r_c_b)
                   && (~bus.req_op[0] == r_c_sign);
`endif

    assign w_a_abs = abs33(r_dv_a, r_dv_sign);
    assign w_b_abs = abs33(r_dv_b, r_dv_sign);

    lzc33 u_lzc_a (.i_val(w_a_abs), .o_cnt(w_n1));
    lzc33 u_lzc_b (.i_val(w_b_abs), .o_cnt(w_n2));

    always_comb begin
        w_next        = r_state;
        w_capture     = 1'b0;
        w_ready       = r_rst_done && (r_state == ST_IDLE) && !dv_busy && !flush;
        w_accept      = w_ready && bus.req_valid;
        bus.req_ready = w_ready;
        bus.rsp_valid = (r_state == ST_DONE);
        bus.rsp_data  = r_op_rem ? r_rem : r_quo;
        dv_en         = (r_state == ST_RUN);
        busy          = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef DIV_RESULT_CACHE_EN
                    w_next = w_hit ? ST_DONE : ST_PREP;
`else
                    w_next = ST_PREP;
`endif
                end
            end
            ST_PREP: w_next = ST_RUN;
            ST_RUN: begin
                // The core's stall flag is only meaningful after its start cycle.
                if (!r_first_run && !dv_busy) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase

        if (flush) begin
            w_next    = ST_IDLE;
            w_capture = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rst_done  <= 1'b0;
            r_first_run <= 1'b0;
            r_op_rem    <= 1'b0;
            r_dv_a      <= '0;
            r_dv_b      <= '0;
            r_dv_sign   <= 1'b0;
            r_a_opuns   <= '0;
            r_b_opuns   <= '0;
            r_n1        <= '0;
            r_n2        <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
        end else begin
            r_state     <= w_next;
            r_rst_done  <= 1'b1;
            r_first_run <= (r_state == ST_PREP);
            // accept stage
            if (w_accept) begin
                r_dv_a    <= bus.req_a;
                r_dv_b    <= bus.req_b;
                r_dv_sign <= ~bus.req_op[0];
                r_op_rem  <= bus.req_op[1];
            end
            // operand preparation stage
            if (r_state == ST_PREP) begin
                r_a_opuns <= w_a_abs;
                r_b_opuns <= w_b_abs;
                r_n1      <= w_n1;
                r_n2      <= w_n2;
            end
            // result capture stage
            if (w_capture) begin
                r_quo <= dv_quo;
                r_rem <= dv_rem;
            end
`ifdef DIV_RESULT_CACHE_EN
            if (w_accept && w_hit) begin
                r_quo <= r_c_quo;
                r_rem <= r_c_rem;
            end
`endif
        end
    end

`ifdef DIV_RESULT_CACHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_a    <= '0;
            r_c_b    <= '0;
            r_c_sign <= 1'b0;
            r_c_quo  <= '0;
            r_c_rem  <= '0;
            r_c_vld  <= 1'b0;
        end else if (flush) begin
            r_c_vld <= 1'b0;
        end else if (w_capture) begin
            r_c_a    <= r_dv_a;
            r_c_b    <= r_dv_b;
            r_c_sign <= r_dv_sign;
            r_c_quo  <= dv_quo;
            r_c_rem  <= dv_rem;
            r_c_vld  <= 1'b1;
        end
    end
`endif

    assign dv_a       = r_dv_a;
    assign dv_b       = r_dv_b;
    assign dv_sign    = r_dv_sign;
    assign dv_a_opuns = r_a_opuns;
    assign dv_b_opuns = r_b_opuns;
    assign dv_n1      = r_n1;
    assign dv_n2      = r_n2;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed testbench for div_seq_ctrl with a behavioural divider core model.
// Build option: DIV_RESULT_CACHE_EN selects the cached-result expectations.
`timescale 1ns/1ps
module tb_div_seq_ctrl;
    import div_pkg::*;

`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        busy;
    logic [31:0] dv_a, dv_b, dv_quo, dv_rem;
    logic        dv_sign, dv_en, dv_busy;
    logic [32:0] dv_a_opuns, dv_b_opuns;
    logic [5:0]  dv_n1, dv_n2;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int c0    = 0;
    int en_cnt = 0;

    div_seq_ctrl_if u_if ();

    div_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(u_if), .flush(flush), .busy(busy),
        .dv_a(dv_a), .dv_b(dv_b), .dv_sign(dv_sign), .dv_en(dv_en),
        .dv_a_opuns(dv_a_opuns), .dv_b_opuns(dv_b_opuns),
        .dv_n1(dv_n1), .dv_n2(dv_n2),
        .dv_quo(dv_quo), .dv_rem(dv_rem), .dv_busy(dv_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (dv_en) en_cnt <= en_cnt + 1;

    // ---------------- divider core model ----------------
    function automatic logic [31:0] core_quo(input logic [31:0] a, b, input logic s);
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        if (s) return $signed(a) / $signed(b);
        return a / b;
    endfunction

    function automatic logic [31:0] core_rem(input logic [31:0] a, b, input logic s);
        if (b == 32'd0) return a;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        if (s) return $signed(a) % $signed(b);
        return a % b;
    endfunction

    function automatic int core_lat(input logic [32:0] ao, bo, input logic [5:0] n1, n2);
        if (bo == 33'd0 || bo == 33'd1 || ao < bo) return 0;
        return int'(n2) - int'(n1);
    endfunction

    logic        en_q  = 1'b0;
    int          cnt   = 0;
    logic [31:0] m_quo = '0;
    logic [31:0] m_rem = '0;

    assign dv_busy = (cnt != 0);
    assign dv_quo  = m_quo;
    assign dv_rem  = m_rem;

    always @(posedge clk) begin
        en_q <= dv_en;
        if (dv_en && !en_q) begin
            m_quo <= core_quo(dv_a, dv_b, dv_sign);
            m_rem <= core_rem(dv_a, dv_b, dv_sign);
            cnt   <= core_lat(dv_a_opuns, dv_b_opuns, dv_n1, dv_n2);
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [1:0] op, input logic [31:0] a, b, output int wt);
        @(negedge clk);
        u_if.req_valid = 1'b1;
        u_if.req_op    = op;
        u_if.req_a     = a;
        u_if.req_b     = b;
        #1;
        wt = 0;
        while (!u_if.req_ready && wt < 200) begin
            @(negedge clk);
            #1;
            wt++;
        end
        chk("accept_ready", {63'd0, u_if.req_ready}, 64'd1);
        c0 = cyc;
        @(posedge clk);
        #1 u_if.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u_if.rsp_valid && n < 200);
        lat = cyc - c0;
    endtask

    task automatic take_rsp();
        u_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1 u_if.rsp_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, b,
                          input logic [31:0] exp_data, input int exp_lat);
        int wt, lat;
        start_req(op, a, b, wt);
        wait_rsp(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_vld"}, {63'd0, u_if.rsp_valid}, 64'd1);
        chk({tag, "_data"}, {32'd0, u_if.rsp_data}, {32'd0, exp_data});
    endtask

    function automatic int hl(input int full);
        return CACHE ? 1 : full;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt, lat, e0;
        rst_n          = 1'b0;
        flush          = 1'b0;
        u_if.req_valid = 1'b0;
        u_if.req_op    = 2'b00;
        u_if.req_a     = '0;
        u_if.req_b     = '0;
        u_if.rsp_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, u_if.req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, u_if.rsp_valid}, 64'd0);
        chk("rst_rsp_data", {32'd0, u_if.rsp_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_dv_en", {63'd0, dv_en}, 64'd0);
        chk("rst_opuns", {31'd0, dv_a_opuns}, 64'd0);
        chk("rst_n1", {58'd0, dv_n1}, 64'd0);
        rst_n = 1'b1;
        #1 chk("rdy_at_release", {63'd0, u_if.req_ready}, 64'd0);
        @(negedge clk);
        chk("rdy_after_edge", {63'd0, u_if.req_ready}, 64'd1);

        // DIV -7 / 2, then REM
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5);
        chk("m7_aopuns", {31'd0, dv_a_opuns}, 64'd7);
        chk("m7_bopuns", {31'd0, dv_b_opuns}, 64'd2);
        chk("m7_n1", {58'd0, dv_n1}, 64'd30);
        chk("m7_n2", {58'd0, dv_n2}, 64'd31);
        chk("m7_sign", {63'd0, dv_sign}, 64'd1);
        chk("m7_done_en", {63'd0, dv_en}, 64'd0);
        chk("m7_done_busy", {63'd0, busy}, 64'd1);
        take_rsp();
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, hl(5));
        take_rsp();

        // divide by zero
        run_op("divu_100_0", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 4);
        take_rsp();
        run_op("remu_100_0", OP_REMU, 32'd100, 32'd0, 32'd100, hl(4));
        take_rsp();

        // signed overflow
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4);
        chk("ovf_aopuns", {31'd0, dv_a_opuns}, 64'h0_8000_0000);
        chk("ovf_bopuns", {31'd0, dv_b_opuns}, 64'd1);
        take_rsp();
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, hl(4));
        take_rsp();

        // general case with response backpressure
        run_op("divu_ff_3", OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34);
        chk("ff3_n1", {58'd0, dv_n1}, 64'd1);
        chk("ff3_n2", {58'd0, dv_n2}, 64'd31);
        chk("ff3_sign", {63'd0, dv_sign}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_vld", {63'd0, u_if.rsp_valid}, 64'd1);
            chk("hold_data", {32'd0, u_if.rsp_data}, 64'h5555_5555);
            chk("hold_en", {63'd0, dv_en}, 64'd0);
        end
        take_rsp();
        @(negedge clk);
        chk("after_take_busy", {63'd0, busy}, 64'd0);

        // flush in the second RUN cycle of an early-out operation
        start_req(OP_DIVU, 32'hFFFF_FFFF, 32'd1, wt);
        @(negedge clk);
        @(negedge clk);
        chk("fl1_en", {63'd0, dv_en}, 64'd1);
        @(negedge clk);
        flush = 1'b1;
        #1 chk("fl1_rdy", {63'd0, u_if.req_ready}, 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("fl1_busy", {63'd0, busy}, 64'd0);
        chk("fl1_en_off", {63'd0, dv_en}, 64'd0);
        repeat (3) @(negedge clk);
        chk("fl1_no_rsp", {63'd0, u_if.rsp_valid}, 64'd0);

        // flush while the core keeps counting; next request waits for it
        start_req(OP_DIVU, 32'hFFFF_FFFF, 32'd5, wt);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush          = 1'b1;
        u_if.req_valid = 1'b1;
        u_if.req_op    = OP_DIVU;
        u_if.req_a     = 32'd10;
        u_if.req_b     = 32'd3;
        #1 chk("fl2_rdy", {63'd0, u_if.req_ready}, 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        start_req(OP_DIVU, 32'd10, 32'd3, wt);
        chk("fl2_wait", wt, 64'd28);
        wait_rsp(lat);
        chk("divu_10_3_lat", lat, 64'd6);
        chk("divu_10_3_data", {32'd0, u_if.rsp_data}, 64'd3);
        take_rsp();

        // result cache pair
        run_op("div_1000_7", OP_DIV, 32'd1000, 32'd7, 32'd142, 11);
        take_rsp();
        e0 = en_cnt;
        run_op("rem_1000_7", OP_REM, 32'd1000, 32'd7, 32'd6, hl(11));
        chk("rem_1000_7_en", en_cnt - e0, CACHE ? 64'd0 : 64'd9);
        take_rsp();

        // a flush in IDLE empties the cache
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        run_op("div_1000_7b", OP_DIV, 32'd1000, 32'd7, 32'd142, 11);
        take_rsp();

        // reset mid-operation
        start_req(OP_DIVU, 32'd10, 32'd3, wt);
        @(negedge clk);
        @(negedge clk);
        chk("mid_en", {63'd0, dv_en}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {63'd0, busy}, 64'd0);
        chk("mid_en_off", {63'd0, dv_en}, 64'd0);
        chk("mid_data", {32'd0, u_if.rsp_data}, 64'd0);
        chk("mid_opuns", {31'd0, dv_b_opuns}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_no_rsp", {63'd0, u_if.rsp_valid}, 64'd0);
        chk("mid_idle", {63'd0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
